// File: rtl/core_scoreboard_if.sv
// Decode/kill/writeback bundle of the register scoreboard.
// The master side drives the pipeline signals; the slave side is the scoreboard.
interface core_scoreboard_if #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NKILL = 2
);
  localparam int unsigned IDW = $clog2(NREGS);

  logic                 d_valid;
  logic                 d_flush;
  logic                 d_want_rs1;
  logic                 d_want_rs2;
  logic [IDW-1:0]       d_rs1;
  logic [IDW-1:0]       d_rs2;
  logic                 d_reg_wen;
  logic [IDW-1:0]       d_rd;
  logic                 d_ready;
  logic                 d_stall;
  logic [NKILL-1:0]     k_valid;
  logic [NKILL*IDW-1:0] k_rd;
  logic                 w_valid;
  logic                 w_reg_wen;
  logic [IDW-1:0]       w_rd;
  logic [NREGS-1:0]     busy;
  logic                 sb_err;

  modport master (
    output d_valid, d_flush, d_want_rs1, d_want_rs2, d_rs1, d_rs2,
           d_reg_wen, d_rd, d_ready, k_valid, k_rd, w_valid, w_reg_wen, w_rd,
    input  d_stall, busy, sb_err
  );

  modport slave (
    input  d_valid, d_flush, d_want_rs1, d_want_rs2, d_rs1, d_rs2,
           d_reg_wen, d_rd, d_ready, k_valid, k_rd, w_valid, w_reg_wen, w_rd,
    output d_stall, busy, sb_err
  );
endinterface

// File: rtl/core_scoreboard.sv
// Register scoreboard: per-register in-flight write counters, RAW/WAW stall, kill and writeback.
// Define CORE_SCOREBOARD_STALL_CNT_EN to add the 32-bit stall_cycles counter output.
module core_scoreboard #(
  parameter int unsigned NREGS     = 32,
  parameter int unsigned CNTW      = 2,
  parameter int unsigned NKILL     = 2,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  core_scoreboard_if.slave  sb
`ifdef CORE_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int unsigned IDW = $clog2(NREGS);
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [CNTW-1:0]  cnt_q [NREGS];
  logic [CNTW-1:0]  cnt_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  cnt_rs1, cnt_rs2, cnt_rd;
  logic             ret, issue, hit1, hit2, waw_full, stall, range_err;
  logic [NKILL-1:0] kill;
  int               delta, nxt;

  always_comb begin
    cnt_rs1 = cnt_q[sb.d_rs1];
    cnt_rs2 = cnt_q[sb.d_rs2];
    cnt_rd  = cnt_q[sb.d_rd];
    ret     = sb.w_valid & sb.w_reg_wen & (sb.w_rd != '0);
    // A final writeback arriving this cycle releases the reader when bypass is enabled.
    hit1 = sb.d_want_rs1 & (sb.d_rs1 != '0) & (cnt_rs1 != '0)
         & ~((WB_BYPASS != 0) & (cnt_rs1 == CNTW'(1)) & ret & (sb.w_rd == sb.d_rs1));
    hit2 = sb.d_want_rs2 & (sb.d_rs2 != '0) & (cnt_rs2 != '0)
         & ~((WB_BYPASS != 0) & (cnt_rs2 == CNTW'(1)) & ret & (sb.w_rd == sb.d_rs2));
    waw_full = sb.d_reg_wen & (sb.d_rd != '0) & (cnt_rd == CMAX);
    stall    = sb.d_valid & ~sb.d_flush & (hit1 | hit2 | waw_full);
    issue    = sb.d_valid & ~sb.d_flush & ~stall & sb.d_ready & sb.d_reg_wen & (sb.d_rd != '0);
    for (int unsigned k = 0; k < NKILL; k++) begin
      kill[k] = sb.k_valid[k] & (sb.k_rd[k*IDW +: IDW] != '0);
    end
  end

  always_comb begin
    range_err = 1'b0;
    delta     = 0;
    nxt       = 0;
    busy_d    = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      delta = 0;
      if (issue && sb.d_rd == IDW'(r)) delta = delta + 1;
      if (ret && sb.w_rd == IDW'(r))   delta = delta - 1;
      for (int unsigned k = 0; k < NKILL; k++) begin
        if (kill[k] && sb.k_rd[k*IDW +: IDW] == IDW'(r)) delta = delta - 1;
      end
      nxt = int'(cnt_q[r]) + delta;
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (nxt < 0) begin
        cnt_d[r]  = '0;
        range_err = 1'b1;
      end else if (nxt > int'(CMAX)) begin
        cnt_d[r]  = CMAX;
        range_err = 1'b1;
      end else begin
        cnt_d[r] = CNTW'(nxt);
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
    err_d = err_q | range_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign sb.d_stall = stall;
  assign sb.busy    = busy_q;
  assign sb.sb_err  = err_q;

`ifdef CORE_SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif
endmodule

// File: doc/core_scoreboard.md
CORE_SCOREBOARD -- requirements
Module: core_scoreboard

Interface
REQ-001 Parameter NREGS, default 32: number of architectural registers, power of two, at least 2; IDW = log2(NREGS).
REQ-002 Parameter CNTW, default 2: width of the per-register in-flight write counter; maximum count CMAX = 2^CNTW-1.
REQ-003 Parameter NKILL, default 2: number of kill channels (squashed in-flight writers).
REQ-004 Parameter WB_BYPASS, default 1: 1 lets a same-cycle final writeback satisfy a read.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; only clock, all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- d_valid  in  1  decode slot holds an instruction.
- d_flush  in  1  decode slot is being flushed.
- d_want_rs1, d_want_rs2  in  1 each  source operand used.
- d_rs1, d_rs2  in  IDW each  source register indices.
- d_reg_wen  in  1  decode instruction writes rd.
- d_rd  in  IDW  destination register index.
- d_ready  in  1  downstream accepts issue this cycle.
- d_stall  out  1  decode must hold, combinational.
- k_valid  in  NKILL  per-channel kill strobe.
- k_rd  in  NKILL*IDW  per-channel killed rd, channel i at bits [i*IDW +: IDW].
- w_valid, w_reg_wen  in  1 each  writeback retiring a register write.
- w_rd  in  IDW  writeback rd.
- busy  out  NREGS  bit r set when cnt[r] != 0, registered.
- sb_err  out  1  sticky underflow/overflow error.

Function
REQ-006 State: one CNTW-bit counter cnt[r] per register r in 1..NREGS-1; register 0 has no counter and always reads as 0.
REQ-007 The block SHALL assert raw_hit(rs) = want & (rs != 0) & (cnt[rs] != 0), except that with WB_BYPASS=1 there is no hit when cnt[rs]==1 and ret hits rs this cycle.
REQ-008 The block SHALL assert waw_full = d_reg_wen & (d_rd != 0) & (cnt[d_rd] == CMAX).
REQ-009 The block SHALL drive d_stall = d_valid & ~d_flush & (raw_hit(rs1) | raw_hit(rs2) | waw_full).
REQ-010 The block SHALL form issue = d_valid & ~d_flush & ~d_stall & d_ready & d_reg_wen & (d_rd != 0).
REQ-011 The block SHALL form ret = w_valid & w_reg_wen & (w_rd != 0).
REQ-012 The block SHALL form kill_i = k_valid[i] & (k_rd_i != 0).
REQ-013 Per register r, next cnt[r] SHALL be cnt[r] + (issue to r) - (ret to r) - (number of kill channels naming r), computed in one cycle.
REQ-014 Simultaneous issue and retire/kill on the same r SHALL net correctly, e.g. issue+ret leaves cnt unchanged.
REQ-015 Decrement below 0 SHALL clamp cnt[r] to 0 and set sb_err.
REQ-016 Increment above CMAX SHALL hold cnt[r] at CMAX and set sb_err; REQ-008 makes this unreachable in legal use.
REQ-017 busy SHALL reflect cnt after the edge, one-cycle latency from issue/ret/kill.
REQ-018 d_stall SHALL have zero latency from inputs and current cnt.
REQ-019 sb_err SHALL remain set until reset.

Reset
REQ-020 While rst_n is low: all cnt = 0, busy = 0, sb_err = 0, stall counter = 0, regardless of clk.
REQ-021 Deassertion SHALL take effect on the first rising edge after rst_n goes high.
REQ-022 Reset mid-operation SHALL discard all pending writes; in-flight retires after reset count as underflow only if they occur after deassertion.

Configuration
REQ-023 Macro CORE_SCOREBOARD_STALL_CNT_EN defined: add output stall_cycles, out, 32 bits.
- stall_cycles increments each cycle d_stall is high and wraps 0xFFFFFFFF to 0.
- stall_cycles resets to 0.
REQ-024 Macro not defined: port stall_cycles and its counter are absent; all other behaviour is identical.

Verification
REQ-025 Scenario RAW: issue rd=5, next cycle decode rs1=5 want_rs1=1 -> d_stall=1, busy[5]=1; then ret rd=5 -> same cycle d_stall=0 (WB_BYPASS=1), busy[5]=0 next cycle.
REQ-026 Scenario x0: issue rd=0, then read rs1=0 -> cnt unchanged, busy=0, d_stall=0.
REQ-027 Scenario WAW saturation (CNTW=2): three issues rd=7 -> cnt[7]=3; a fourth writer to rd=7 -> d_stall=1 with no sources wanted; one ret -> issue proceeds.
REQ-028 Scenario kill: issue rd=9 twice, k_valid=2'b11 with both k_rd=9 -> cnt[9]=0, busy[9]=0, sb_err=0.
REQ-029 Scenario underflow/reset: ret rd=3 with cnt[3]=0 -> sb_err=1 and stays set; assert rst_n low mid-stream -> busy=0, sb_err=0 immediately without a clock edge.
REQ-030 Scenario flush/stall counter (macro on): hazard present with d_flush=1 -> d_stall=0 and no issue; 4 stalled cycles -> stall_cycles=4.
